// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helpers, digest word accessors and the search FSM state type.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Word 0 sits in the most significant 32 bits, matching SHA-256 byte order.
    typedef logic [7:0][31:0] digest_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] digest_word(input digest_t d, input logic [2:0] idx);
        return d[3'd7 - idx];
    endfunction

    function automatic digest_t digest_set_word(input digest_t d, input logic [2:0] idx, input logic [31:0] w);
        digest_t r;
        r = d;
        r[3'd7 - idx] = w;
        return r;
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/hashModule.sv
// Combinational SHA-256 compression of one padded block holding a 32-byte message.
// Output is the raw working state a..h after 64 rounds; the IV is not added here.
module hashModule
    import sha256_pkg::*;
(
    input  logic [255:0] i_msg,
    output logic [255:0] o_state
);

    logic [31:0] w_sched [64];
    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    // Message schedule and the fully unrolled round chain.
    always_comb begin
        w_sched = '{default: 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            w_sched[i] = i_msg[255 - 32*i -: 32];
        end
        // Padding: a single 1 bit after the message, bit length 256 in the last word.
        w_sched[8]  = 32'h8000_0000;
        w_sched[15] = 32'h0000_0100;
        for (int i = 16; i < 64; i++) begin
            w_sched[i] = ssig1(w_sched[i-2]) + w_sched[i-7] + ssig0(w_sched[i-15]) + w_sched[i-16];
        end

        w_t1 = 32'h0000_0000;
        w_t2 = 32'h0000_0000;
        w_a  = IV[0];
        w_b  = IV[1];
        w_c  = IV[2];
        w_d  = IV[3];
        w_e  = IV[4];
        w_f  = IV[5];
        w_g  = IV[6];
        w_h  = IV[7];
        for (int i = 0; i < 64; i++) begin
            w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + K[i] + w_sched[i];
            w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);
            w_h  = w_g;
            w_g  = w_f;
            w_f  = w_e;
            w_e  = w_d + w_t1;
            w_d  = w_c;
            w_c  = w_b;
            w_b  = w_a;
            w_a  = w_t1 + w_t2;
        end
        o_state = {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h};
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Sweeps a nonce range through the combinational SHA-256 hasher and reports the first digest below target.
// Build option NONCE_SEARCH_CTRL_PERF_EN adds the hash_count output.
module nonce_search_ctrl
    import sha256_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NONCE_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [255:0]       base_msg,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [255:0]       target,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [255:0]       found_hash
`ifdef NONCE_SEARCH_CTRL_PERF_EN
    ,
    output logic [31:0]        hash_count
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [255:0]         r_hasher_in;
    logic [NONCE_W-1:0]   r_nonce_end;
    logic [255:0]         r_target;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_found;
    logic [NONCE_W-1:0]   r_found_nonce;
    logic [255:0]         r_found_hash;

    digest_t              w_hasher_out;
    digest_t              w_digest;
    logic                 w_hit;
    logic [NONCE_W-1:0]   w_nonce;
    logic                 w_last;
    logic                 w_unused_lo;

    // The low message bits are always overwritten by the nonce.
    assign w_unused_lo = ^base_msg[NONCE_W-1:0];

    // The current nonce lives in the low bits of the registered hasher input.
    assign w_nonce = r_hasher_in[NONCE_W-1:0];
    assign w_last  = (w_nonce == r_nonce_end);

    hashModule u_hash (
        .i_msg   (r_hasher_in),
        .o_state (w_hasher_out)
    );

    // IV feed-forward turns the raw compression state into the digest.
    always_comb begin
        w_digest = '0;
        for (int i = 0; i < 8; i++) begin
            w_digest = digest_set_word(w_digest, 3'(i), digest_word(w_hasher_out, 3'(i)) + IV[i]);
        end
    end

    assign w_hit = (w_digest < r_target);

    // Search sequencer; hasher_in only changes on SETTLE entry so the hasher path is multicycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_hasher_in   <= '0;
            r_nonce_end   <= '0;
            r_target      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_hasher_in   <= {base_msg[255:NONCE_W], nonce_start};
                        r_nonce_end   <= nonce_end;
                        r_target      <= target;
                        r_found       <= 1'b0;
                        r_found_nonce <= '0;
                        r_found_hash  <= '0;
                        r_busy        <= 1'b1;
                        r_cnt         <= CNT_LOAD;
                        r_state       <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cnt == '0) begin
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_hit) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= w_nonce;
                        r_found_hash  <= w_digest;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= DONE;
                    end else if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_hasher_in[NONCE_W-1:0] <= w_nonce + NONCE_ONE;
                        r_cnt                    <= CNT_LOAD;
                        r_state                  <= SETTLE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef NONCE_SEARCH_CTRL_PERF_EN
    logic [31:0] r_hash_count;

    // Saturating count of evaluated nonces; a CHECK overridden by abort is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hash_count <= 32'h0000_0000;
        end else if (r_state == IDLE && start) begin
            r_hash_count <= 32'h0000_0000;
        end else if (r_state == CHECK && !abort && r_hash_count != 32'hFFFF_FFFF) begin
            r_hash_count <= r_hash_count + 32'h0000_0001;
        end else begin
            r_hash_count <= r_hash_count;
        end
    end

    assign hash_count = r_hash_count;
`else
    // Without the option neither the counter nor its port exists.
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign found_hash  = r_found_hash;

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
Sequencer that sweeps a 32-bit nonce range through the combinational SHA-256 hasher (hashModule, single 512-bit block for a 32-byte message).
- Registers each candidate message and waits a fixed settle window, because the hasher is a multicycle path.
- Adds the IV feed-forward to form the digest, since the hasher outputs raw compression state.
- Compares the digest against a target and reports the first hit.
- Sits between the host/config logic and the hasher instance.

Parameters:
SETTLE_CYCLES, 4, cycles the hasher input is held stable before its output is sampled (>=1)
NONCE_W, 32, nonce width; occupies the least-significant message word

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a search; sampled only in IDLE
abort  in  1  terminate the current search
base_msg  in  256  message template; bits [255:32] used, [31:0] replaced by the nonce
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce, inclusive
target  in  256  hit when digest < target, unsigned, bit 255 = MSB of digest word 0
busy  out  1  search in progress
done  out  1  one-cycle completion pulse
found  out  1  last search hit; held until next start
found_nonce  out  32  nonce of the hit
found_hash  out  256  digest of the hit (IV added)

Behaviour:
- Reset: rst_n sampled low at a rising edge forces state IDLE and clears busy, done, found, found_nonce, found_hash and the settle counter. This holds mid-search; no partial results are kept.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, on start=1:
  - Latch base_msg, nonce_end and target.
  - Set nonce=nonce_start and hasher_in={base_msg[255:32], nonce}.
  - Clear found, found_nonce and found_hash.
  - Set busy=1, load cnt=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement cnt; go to CHECK when cnt==0. The SETTLE state lasts exactly SETTLE_CYCLES cycles.
- CHECK: compute digest word i = hasher_out word i + IV[i] mod 2^32.
  - Hit if digest < target (strict; equality is a miss). On a hit, load found=1, found_nonce and found_hash, go to DONE.
  - Else if nonce==nonce_end, go to DONE with found=0.
  - Else nonce=nonce+1 (mod 2^32), re-register hasher_in, cnt=SETTLE_CYCLES-1, go to SETTLE.
- DONE: done=1 for this cycle only, busy=0, go to IDLE.
- Latency:
  - Single nonce: done is high SETTLE_CYCLES+2 cycles after the start edge.
  - Each further nonce adds SETTLE_CYCLES+1 cycles.
- Wrap-around: if nonce_end < nonce_start, the sweep passes 0xFFFFFFFF -> 0x00000000 and ends at nonce_end. nonce_start==nonce_end evaluates exactly one nonce.
- abort=1 in SETTLE or CHECK goes to DONE next cycle with found=0. In CHECK, abort takes priority over a hit. abort in IDLE or DONE has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins.
- hasher_in only changes on SETTLE entry, so the hasher's combinational path is constrained as multicycle SETTLE_CYCLES.

Optional Feature:
NONCE_SEARCH_CTRL_PERF_EN
- Defined: adds output hash_count[31:0], the number of nonces evaluated in the current/last search.
  - Cleared on start, incremented in every CHECK that is not overridden by abort.
  - Saturates at 0xFFFFFFFF and holds after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sha256_pkg:
  - SHA-256 IV constants (6a09e667 ... 5be0cd19).
  - Round-constant array.
  - 256-bit digest typedef with 8x32 word accessors.
  - State enum {IDLE, SETTLE, CHECK, DONE}.
- One sub-module: hashModule, instantiated unchanged.
- Feed-forward adder and comparator stay inline.

Test Plan:
1. base_msg=0, nonce_start=nonce_end=0, target=all-ones -> done at cycle SETTLE_CYCLES+2, found=1, found_nonce=0, found_hash=66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925.
2. Same message, target=66687aad...0d5f2925 (equal) -> found=0 (strict compare); target=that value+1 -> found=1.
3. nonce_start=5, nonce_end=9, target=0 -> done after 5*(SETTLE_CYCLES+1)+1 cycles, found=0, hash_count=5 (with PERF_EN).
4. nonce_start=FFFFFFFE, nonce_end=1, target=0 -> hasher_in low words seen in order FFFFFFFE, FFFFFFFF, 0, 1; hash_count=4.
5. abort in 2nd SETTLE cycle of a long sweep -> done next cycle, found=0, busy=0; start pulsed while busy has no effect.
6. rst_n low for one edge during SETTLE -> all outputs 0 next cycle, state IDLE; a new start then runs scenario 1 correctly.
